// File: rtl/pipe_arb_pkg.sv
// Shared types for the pipeline memory arbiter: FSM state encoding and
// the owner IDs that tag which requester holds the memory.
package pipe_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/pipe_arb_lat_cnt.sv
// Loadable down-counter that times the memory latency. Loaded with MEM_LAT
// while the access strobe is out; done flags the edge at which the read data
// is sampled (count == 1).
module pipe_arb_lat_cnt #(
  parameter int MEM_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt_d, cnt_q;

  // Next count: load has priority, decrement stops at zero.
  always_comb begin
    // NOTE: assign a default before any branch so no path can infer a latch.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(MEM_LAT);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values, regardless of block ordering.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbiter sharing one single-ported memory between the IF (fetch) and MEM
// (load/store) pipeline stages. Data side has fixed priority. Each access is
// IDLE/RESP -> ISSUE (m_en) -> WAIT (MEM_LAT edges) -> RESP (ready pulse).
// Optional build macro PIPE_MEM_ARBITER_PERF_EN adds conflict and stall
// counters (perf_conflict, perf_stall_cyc).
module pipe_mem_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          if_stall,
  output logic          d_stall,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
`ifdef PIPE_MEM_ARBITER_PERF_EN
  output logic [31:0]   perf_conflict,
  output logic [31:0]   perf_stall_cyc,
`endif
  output logic          busy
);

  arb_state_e    state_d, state_q;
  owner_e        owner_d, owner_q;
  logic          m_en_d, m_en_q;
  logic          m_we_d, m_we_q;
  logic [AW-1:0] m_addr_d, m_addr_q;
  logic [DW-1:0] m_wdata_d, m_wdata_q;
  logic          if_ready_d, if_ready_q;
  logic          d_ready_d, d_ready_q;
  logic [DW-1:0] if_rdata_d, if_rdata_q;
  logic [DW-1:0] d_rdata_d, d_rdata_q;
  logic          busy_d, busy_q;

  logic          arb_edge;
  logic          if_vld;
  logic          d_vld;
  logic          lat_done;

  // In RESP the served requester still shows its old req, so it is masked
  // for this one arbitration to avoid a duplicate access.
  assign arb_edge = (state_q == IDLE) || (state_q == RESP);
  assign if_vld   = if_req && !((state_q == RESP) && (owner_q == OWN_IF));
  assign d_vld    = d_req  && !((state_q == RESP) && (owner_q == OWN_D));

  pipe_arb_lat_cnt #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clock (clock),
    .reset (reset),
    .load  (state_q == ISSUE),
    .dec   (state_q == WAIT),
    .done  (lat_done)
  );

  // FSM next state, arbitration, grant latching and read-data capture.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    m_en_d     = 1'b0;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      IDLE, RESP: begin
        if (d_vld) begin
          state_d   = ISSUE;
          owner_d   = OWN_D;
          m_en_d    = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (if_vld) begin
          state_d  = ISSUE;
          owner_d  = OWN_IF;
          m_en_d   = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = if_addr;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_done) begin
          state_d = RESP;
          if (owner_q == OWN_D) begin
            d_ready_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = m_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any in-flight access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign m_en     = m_en_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = busy_q;
  assign if_stall = if_req && !if_ready_q;
  assign d_stall  = d_req && !d_ready_q;

`ifdef PIPE_MEM_ARBITER_PERF_EN
  logic [31:0] perf_conflict_d, perf_conflict_q;
  logic [31:0] perf_stall_cyc_d, perf_stall_cyc_q;

  // Wrapping event counters: contested arbitrations and stalled cycles.
  always_comb begin
    perf_conflict_d  = perf_conflict_q + {31'd0, (arb_edge && if_vld && d_vld)};
    perf_stall_cyc_d = perf_stall_cyc_q + {31'd0, (if_stall || d_stall)};
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_conflict_q  <= '0;
      perf_stall_cyc_q <= '0;
    end else begin
      perf_conflict_q  <= perf_conflict_d;
      perf_stall_cyc_q <= perf_stall_cyc_d;
    end
  end

  assign perf_conflict  = perf_conflict_q;
  assign perf_stall_cyc = perf_stall_cyc_q;
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter (MEM_LAT=2): hand sequences for
// the multi-cycle corners, a transaction table, and a randomized two-port
// run against a behavioural memory/requester model.
module tb_pipe_mem_arbiter;

  localparam int MEM_LAT = 2;
  localparam int L       = MEM_LAT + 2;  // cycle index of the ready pulse, req cycle = 0
  localparam int NRAND   = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        if_stall;
  logic        d_stall;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        busy;
`ifdef PIPE_MEM_ARBITER_PERF_EN
  logic [31:0] perf_conflict;
  logic [31:0] perf_stall_cyc;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(MEM_LAT)) dut (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .if_stall (if_stall),
    .d_stall  (d_stall),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
`ifdef PIPE_MEM_ARBITER_PERF_EN
    .perf_conflict  (perf_conflict),
    .perf_stall_cyc (perf_stall_cyc),
`endif
    .busy     (busy)
  );

  // ---------------- memory model ----------------
  // Word-indexed by addr[13:2]; unwritten words return init_val().
  // m_rdata is valid only in the cycle before the sampling edge, garbage otherwise.
  logic [31:0] mem [0:4095];
  bit          wr  [0:4095];
  logic [11:0] pend_idx = '0;
  int          pend_left = 0;

  function automatic logic [31:0] init_val(input logic [11:0] idx);
    case (idx)
      12'h040: return 32'h8C010004;  // 0x100
      12'h041: return 32'h11112222;  // 0x104
      12'h800: return 32'h0000ABCD;  // 0x2000
      12'h802: return 32'h00001234;  // 0x2008
      12'h004: return 32'hA0A00010;  // 0x10
      12'h005: return 32'hB0B00014;  // 0x14
      default: return {idx, 8'h5A, idx};
    endcase
  endfunction

  always @(posedge clock) begin
    if (m_en) begin
      if (m_we) begin
        mem[m_addr[13:2]] <= m_wdata;
        wr[m_addr[13:2]]  <= 1'b1;
      end
      pend_idx  <= m_addr[13:2];
      pend_left <= MEM_LAT;
    end else if (pend_left > 0) begin
      pend_left <= pend_left - 1;
    end
  end

  assign m_rdata = (pend_left == 1) ? (wr[pend_idx] ? mem[pend_idx] : init_val(pend_idx))
                                    : 32'hBAD0BAD0;

  // ---------------- monitors for the random phase ----------------
  bit mon_en = 0;
  int men_total = 0;
  int both_rdy = 0;
  always @(negedge clock) begin
    if (mon_en) begin
      if (m_en) men_total++;
      if (if_ready && d_ready) both_rdy++;
    end
  end

  // Watchdog: bench must never hang.
  initial begin
    #400000;
    $display("FAIL watchdog expired act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- table-driven transactions ----------------
  typedef struct {
    bit          do_if;
    logic [31:0] if_addr;
    bit          do_d;
    bit          d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] exp_if_data;
    logic [31:0] exp_d_data;
  } vec_t;

  logic [31:0] exp_d_last = '0;  // model of the d_rdata register

  // Apply one record at the current negedge, observe 12 cycles, compare.
  task automatic run_vec(input vec_t v, input string nm);
    int if_cyc, d_cyc, men, men_last;
    logic [31:0] if_dat, d_dat, p_addr, p_wdata;
    logic p_we;
    if_cyc = -1; d_cyc = -1; men = 0; men_last = -1;
    if_dat = '0; d_dat = '0; p_addr = '0; p_wdata = '0; p_we = 1'b0;
    if_req = v.do_if; if_addr = v.if_addr;
    d_req = v.do_d; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (m_en) begin
        if (men == 0) begin p_addr = m_addr; p_we = m_we; p_wdata = m_wdata; end
        men++;
        men_last = k;
      end
      if (if_ready) begin
        if (if_cyc < 0) begin if_cyc = k; if_dat = if_rdata; end
        if_req = 1'b0;
      end
      if (d_ready) begin
        if (d_cyc < 0) begin d_cyc = k; d_dat = d_rdata; end
        d_req = 1'b0;
      end
    end
    if (v.do_if) begin
      check($sformatf("%s_if_cycle", nm), if_cyc, v.do_d ? 2 * L : L);
      check($sformatf("%s_if_rdata", nm), if_dat, v.exp_if_data);
    end
    if (v.do_d) begin
      check($sformatf("%s_d_cycle", nm), d_cyc, L);
      check($sformatf("%s_d_rdata", nm), d_dat, v.exp_d_data);
      if (!v.d_we) exp_d_last = v.exp_d_data;
    end
    check($sformatf("%s_men_count", nm), men, int'(v.do_if) + int'(v.do_d));
    check($sformatf("%s_men_last", nm), men_last, (v.do_if && v.do_d) ? L + 1 : 1);
    check($sformatf("%s_first_addr", nm), p_addr, v.do_d ? v.d_addr : v.if_addr);
    check($sformatf("%s_first_we", nm), p_we, v.do_d ? v.d_we : 1'b0);
    if (v.do_d && v.d_we) check($sformatf("%s_first_wdata", nm), p_wdata, v.d_wdata);
    check($sformatf("%s_busy_end", nm), busy, 1'b0);
  endtask

  // ---------------- randomized requesters ----------------
  logic [31:0] dref [0:15];

  task automatic rand_if(input int n);
    logic [11:0] idx;
    int w, gap;
    bit got;
    for (int t = 0; t < n; t++) begin
      idx = 12'h080 + 12'($urandom_range(0, 127));
      if_req = 1'b1;
      if_addr = {18'd0, idx, 2'b00};
      w = 0; got = 0;
      while (!got && w < 40) begin
        @(negedge clock);
        w++;
        if (if_ready) got = 1;
      end
      check("rand_if_ready", got, 1'b1);
      if (!got) break;
      check("rand_if_rdata", if_rdata, {idx, 8'h5A, idx});
      gap = $urandom_range(0, 2);
      if (gap != 0 || t == n - 1) begin
        if_req = 1'b0;
        repeat (gap) @(negedge clock);
      end
    end
    if_req = 1'b0;
  endtask

  task automatic rand_d(input int n);
    int i, w, gap;
    bit got, st;
    logic [31:0] wd;
    for (int t = 0; t < n; t++) begin
      i  = $urandom_range(0, 15);
      st = 1'($urandom_range(0, 1));
      wd = $urandom;
      d_req = 1'b1; d_we = st; d_addr = 32'h3000 + 32'(4 * i); d_wdata = wd;
      w = 0; got = 0;
      while (!got && w < 40) begin
        @(negedge clock);
        w++;
        if (d_ready) got = 1;
      end
      check("rand_d_ready", got, 1'b1);
      if (!got) break;
      if (st) begin
        check("rand_d_store_keeps_rdata", d_rdata, exp_d_last);
        dref[i] = wd;
      end else begin
        check("rand_d_load_rdata", d_rdata, dref[i]);
        exp_d_last = dref[i];
      end
      gap = $urandom_range(0, 2);
      if (gap != 0 || t == n - 1) begin
        d_req = 1'b0;
        repeat (gap) @(negedge clock);
      end
    end
    d_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs [6];

  initial begin
    int men, rdy, rdy2_cyc, bad;
    vec_t v;

    vecs[0] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0,        32'h11112222, 32'h0000ABCD};
    vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h2008, 32'h0,        32'h0,        32'h00001234};
    vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 32'h0,        32'h00001234};
    vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h2004, 32'h0,        32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h2008, 32'h55AA55AA, 32'h8C010004, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 32'h104, 1'b0, 1'b0, 32'h0,    32'h0,        32'h11112222, 32'h0};

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_ctl", {if_ready, d_ready, m_en, m_we, busy, if_stall, d_stall}, 7'b0);
    check("rst_addr_data", {m_addr, m_wdata}, 64'h0);
    check("rst_rdata", {if_rdata, d_rdata}, 64'h0);

    // Lone fetch, cycle by cycle
    @(negedge clock);
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      check($sformatf("t1_men_c%0d", k), m_en, k == 1);
      check($sformatf("t1_ready_c%0d", k), if_ready, k == L);
      check($sformatf("t1_stall_c%0d", k), if_stall, k < L);
      check($sformatf("t1_busy_c%0d", k), busy, k <= L);
      if (k == 1) check("t1_maddr", {m_addr, 31'd0, m_we}, {32'h100, 32'h0});
      if (k == L) begin
        check("t1_rdata", if_rdata, 32'h8C010004);
        if_req = 1'b0;
      end
    end

    // Transaction table
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // d_req held across two loads, address changed in the ready cycle
    men = 0; rdy = 0; rdy2_cyc = -1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      if (m_en) begin
        men++;
        if (men == 2) check("t4_maddr2", m_addr, 32'h14);
      end
      if (d_ready) begin
        rdy++;
        if (rdy == 1) begin
          check("t4_rdata1", d_rdata, 32'hA0A00010);
          d_addr = 32'h14;
        end else begin
          check("t4_rdata2", d_rdata, 32'hB0B00014);
          rdy2_cyc = k;
          d_req = 1'b0;
        end
      end
    end
    check("t4_men_count", men, 2);
    check("t4_ready_count", rdy, 2);
    check("t4_ready2_cycle", rdy2_cyc, 2 * L + 1);

    // Reset asserted in WAIT during a fetch
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clock);
    @(negedge clock);
    check("t5_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("t5_ctl", {if_ready, d_ready, m_en, m_we, busy}, 5'b0);
    check("t5_maddr", m_addr, 32'h0);
    check("t5_rdata", {if_rdata, d_rdata}, 64'h0);
    if_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_d_last = '0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (if_ready || busy || m_en) bad++;
    end
    check("t5_quiet_after_release", bad, 0);
    run_vec(vecs[5], "t5_new_fetch");

`ifdef PIPE_MEM_ARBITER_PERF_EN
    begin
      logic [31:0] pc0, ps0;
      pc0 = perf_conflict;
      ps0 = perf_stall_cyc;
      v = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0, 32'h11112222, 32'h0000ABCD};
      run_vec(v, "perf");
      check("perf_conflict_delta", perf_conflict - pc0, 32'd1);
      check("perf_stall_delta", perf_stall_cyc - ps0, 32'd8);
    end
`endif

    // Randomized concurrent traffic
    for (int i = 0; i < 16; i++) dref[i] = init_val(12'hC00 + 12'(i));
    men_total = 0; both_rdy = 0;
    mon_en = 1;
    fork
      rand_if(NRAND);
      rand_d(NRAND);
    join
    repeat (4) @(negedge clock);
    mon_en = 0;
    check("rand_men_total", men_total, 2 * NRAND);
    check("rand_both_ready", both_rdy, 0);
    check("rand_busy_end", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Sequences every access with a fixed memory latency.
- Returns registered read data and a one-cycle ready pulse to the requester it served.
- Produces per-requester stall signals that the pipeline uses to freeze PC/IR (IF) or the EXE/MEM/WB registers (MEM).

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, edges from the edge ending the m_en cycle to the edge at which m_rdata is sampled. Must be >=1; 1 means synchronous RAM.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready is seen.
- if_addr  in  AW  fetch address.
- if_ready  out  1  one-cycle pulse: fetch done, if_rdata valid.
- if_rdata  out  DW  registered fetched instruction.
- d_req  in  1  data request; held until d_ready is seen.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ready  out  1  one-cycle pulse: data access done.
- d_rdata  out  DW  registered load data.
- if_stall  out  1  if_req & ~if_ready (combinational).
- d_stall  out  1  d_req & ~d_ready (combinational).
- m_en  out  1  memory access strobe; high exactly one cycle per access.
- m_we  out  1  memory write enable; valid with m_en.
- m_addr  out  AW  memory address, registered at grant.
- m_wdata  out  DW  memory write data, registered at grant.
- m_rdata  in  DW  memory read data.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0. Reset asserted mid-access forces IDLE at once, and the in-flight result is discarded (no ready pulse).
- States:
  - IDLE: not busy.
  - ISSUE: m_en=1, one cycle.
  - WAIT: counts MEM_LAT edges.
  - RESP: exactly one ready output is high.
- Arbitration happens at an edge in IDLE or RESP. A pending d_req wins over if_req (fixed data priority: the older instruction completes first, so there is no deadlock). The winner's addr, we and wdata are latched into m_addr, m_we and m_wdata; an IF grant forces m_we=0. The next state is ISSUE and the owner register is set.
- In RESP, the req of the requester just served is masked for that arbitration, because its req is still the stale one. This gives back-to-back service of the other requester with no idle cycle.
- ISSUE -> WAIT with cnt=MEM_LAT. WAIT decrements cnt each edge. At the edge where cnt==1, m_rdata is captured into the owner's rdata register and the state goes to RESP.
- Latency: req sampled at edge E0, m_en high in cycle C1, ready high in the cycle after edge E(MEM_LAT+1). Loads and stores use identical timing.
- A store does not update d_rdata; d_rdata holds its previous value. if_rdata and d_rdata hold their value until that requester's next completion.
- Requesters must keep req, addr, we and wdata stable from assertion until their ready pulse. Changes before grant are legal; changes after grant are ignored.
- Simultaneous if_req and d_req in IDLE: D is served first. IF is granted at the edge ending D's RESP cycle.
- Requests arriving while busy are held pending and are not lost.

Optional Feature:
- Macro: PIPE_MEM_ARBITER_PERF_EN.
- When defined, adds outputs perf_conflict[31:0] and perf_stall_cyc[31:0], cleared by reset.
  - perf_conflict increments at each arbitration edge where both unmasked requests are high.
  - perf_stall_cyc increments every cycle if_stall|d_stall is 1.
  - Both wrap at 2^32 without saturating.
- When undefined, these ports and registers do not exist, and all other behaviour is identical.

Decomposition:
- Shared package pipe_arb_pkg holds:
  - the state encoding: IDLE, ISSUE, WAIT, RESP;
  - the owner IDs: OWN_IF=0, OWN_D=1.
- One natural sub-module, pipe_arb_lat_cnt: a loadable down-counter with a done flag, parameterised by MEM_LAT. The FSM, arbitration and registers stay in the top module.

Test Plan:
1. MEM_LAT=2, if_req=1 with if_addr=0x100 from E0, memory returns 0x8C010004 -> m_en=1, m_we=0, m_addr=0x100 in C1 only; if_ready high one cycle after E3 with if_rdata=0x8C010004; if_stall=1 until then.
2. Same cycle, if_req at 0x104 and d_req load at 0x2000 (mem 0x0000ABCD) -> D issued first, d_rdata=0x0000ABCD; IF m_en occurs in the cycle after D's RESP cycle; the two m_en pulses are 4 cycles apart; no idle cycle between D's RESP and IF's ISSUE.
3. d_req store d_addr=0x2004, d_wdata=0xDEADBEEF, with d_rdata previously 0x1234 -> one m_en cycle with m_we=1, m_wdata=0xDEADBEEF; d_ready pulses; d_rdata stays 0x1234.
4. d_req held high continuously across two loads (0x10 then 0x14, changed in the ready cycle) -> exactly two m_en pulses; the stale req in RESP does not trigger a duplicate access.
5. reset asserted in WAIT during a fetch -> immediately all outputs 0, busy=0; no if_ready after release; a new if_req after release is served normally.
6. With PIPE_MEM_ARBITER_PERF_EN defined, run scenario 2 -> perf_conflict=1, perf_stall_cyc equals the number of cycles either stall was high (8 with MEM_LAT=2).
